byte_demux: RTL and testbench



---
 rtl/byte_demux.sv | 99 +++++++++
 tb/tb_byte_demux.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_demux.sv
// Byte-wide 1-to-2 distributor: steers each input byte to output 0 or 1 by SEL into a one-entry holding register per output.
// Latency: 1 cycle from input handshake to Vn high; drain and reload on the same edge sustain 1 byte/cycle per path.
// Backpressure: DR drops only when the selected output is full and its consumer is stalled; the other path is never blocked.
// Optional: define BYTE_DEMUX_CNT_EN to add 8-bit per-output transfer counters CNT0/CNT1.
module byte_demux #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    output logic             DR,
    input  logic             SEL,
    output logic [WIDTH-1:0] Q0,
    output logic             V0,
    input  logic             R0,
    output logic [WIDTH-1:0] Q1,
    output logic             V1,
    input  logic             R1
`ifdef BYTE_DEMUX_CNT_EN
    ,
    output logic [7:0]       CNT0,
    output logic [7:0]       CNT1
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    slot_t st0, st0_nxt;
    slot_t st1, st1_nxt;

    logic load0, load1;
    logic drain0, drain1;

    // Each slot's valid is simply its occupancy state.
    assign V0 = (st0 == FULL);
    assign V1 = (st1 == FULL);

    // A slot can accept when empty or when its current byte leaves on this edge.
    assign DR = SEL ? (!V1 | R1) : (!V0 | R0);

    assign load0  = DV & DR & ~SEL;
    assign load1  = DV & DR &  SEL;
    assign drain0 = V0 & R0;
    assign drain1 = V1 & R1;

    // Slot occupancy registers; reset discards any pending bytes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st0 <= EMPTY;
            st1 <= EMPTY;
        end else begin
            st0 <= st0_nxt;
            st1 <= st1_nxt;
        end
    end

    // Next-state: fill on load, empty on drain without a simultaneous reload.
    always_comb begin
        st0_nxt = st0;
        st1_nxt = st1;
        case (st0)
            EMPTY: if (load0) st0_nxt = FULL;
            FULL:  if (drain0 && !load0) st0_nxt = EMPTY;
        endcase
        case (st1)
            EMPTY: if (load1) st1_nxt = FULL;
            FULL:  if (drain1 && !load1) st1_nxt = EMPTY;
        endcase
    end

    // Holding data; retains the last byte after it drains.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q0 <= '0;
            Q1 <= '0;
        end else begin
            if (load0) Q0 <= D;
            if (load1) Q1 <= D;
        end
    end

`ifdef BYTE_DEMUX_CNT_EN
    // Per-output transfer counters, free-running with natural 8-bit wrap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CNT0 <= 8'd0;
            CNT1 <= 8'd0;
        end else begin
            if (drain0) CNT0 <= CNT0 + 8'd1;
            if (drain1) CNT1 <= CNT1 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_byte_demux.sv
// Self-checking bench for byte_demux: directed vector table, corner-case sequences,
// and randomized traffic against a queue-based model of the two holding slots.
// Build with BYTE_DEMUX_CNT_EN defined to also exercise the transfer counters.
module tb_byte_demux;

    logic       clk;
    logic       rst;
    logic [7:0] d;
    logic       dv;
    logic       dr;
    logic       sel;
    logic [7:0] q0;
    logic       v0;
    logic       r0;
    logic [7:0] q1;
    logic       v1;
    logic       r1;
`ifdef BYTE_DEMUX_CNT_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    byte_demux #(.WIDTH(8)) dut (
`ifdef BYTE_DEMUX_CNT_EN
        .CNT0(cnt0),
        .CNT1(cnt1),
`endif
        .CLK(clk),
        .RST(rst),
        .D(d),
        .DV(dv),
        .DR(dr),
        .SEL(sel),
        .Q0(q0),
        .V0(v0),
        .R0(r0),
        .Q1(q1),
        .V1(v1),
        .R1(r1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       dv;
        logic       sel;
        logic       r0;
        logic       r1;
        logic       exp_dr;
        logic       exp_v0;
        logic [7:0] exp_q0;
        logic       exp_v1;
        logic [7:0] exp_q1;
    } vec_t;

    vec_t vt[9];

    // Reference model: each output is a queue holding at most one byte.
    logic [7:0] mq0[$];
    logic [7:0] mq1[$];
    logic [7:0] last0, last1;

    initial begin
        logic acc, tk0, tk1, mdr;

        vt[0] = '{8'h3C, 1, 0, 0, 0, 1, 1, 8'h3C, 0, 8'h00};
        vt[1] = '{8'hC3, 1, 1, 0, 0, 1, 1, 8'h3C, 1, 8'hC3};
        vt[2] = '{8'h11, 1, 0, 0, 0, 0, 1, 8'h3C, 1, 8'hC3};
        vt[3] = '{8'h11, 1, 0, 1, 0, 1, 1, 8'h11, 1, 8'hC3};
        vt[4] = '{8'hFF, 0, 0, 1, 0, 1, 0, 8'h11, 1, 8'hC3};
        vt[5] = '{8'hEE, 0, 1, 0, 1, 1, 0, 8'h11, 0, 8'hC3};
        vt[6] = '{8'h55, 1, 1, 0, 0, 1, 0, 8'h11, 1, 8'h55};
        vt[7] = '{8'h66, 1, 1, 0, 0, 0, 0, 8'h11, 1, 8'h55};
        vt[8] = '{8'h77, 1, 0, 0, 0, 1, 1, 8'h77, 1, 8'h55};

        rst = 1'b1; d = 8'h00; dv = 1'b0; sel = 1'b0; r0 = 1'b0; r1 = 1'b0;
        #2;
        chk("reset_v0", v0, 0);
        chk("reset_v1", v1, 0);
        chk("reset_q0", q0, 0);
        chk("reset_q1", q1, 0);
        chk("reset_dr", dr, 1);
        @(posedge clk); @(posedge clk); #4;
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            d = vt[i].d; dv = vt[i].dv; sel = vt[i].sel; r0 = vt[i].r0; r1 = vt[i].r1;
            #1;
            chk($sformatf("vec%0d_dr", i), dr, vt[i].exp_dr);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_v0", i), v0, vt[i].exp_v0);
            chk($sformatf("vec%0d_q0", i), q0, vt[i].exp_q0);
            chk($sformatf("vec%0d_v1", i), v1, vt[i].exp_v1);
            chk($sformatf("vec%0d_q1", i), q1, vt[i].exp_q1);
            dv = 1'b0; r0 = 1'b0; r1 = 1'b0;
        end

        // Output 0 stalled full with 0x77; stream into output 1 unaffected.
        for (int k = 1; k <= 4; k++) begin
            d = 8'(k); dv = 1'b1; sel = 1'b1; r0 = 1'b0; r1 = 1'b1;
            #1;
            chk($sformatf("indep%0d_dr", k), dr, 1);
            @(posedge clk); #1;
            chk($sformatf("indep%0d_q1", k), q1, k);
            chk($sformatf("indep%0d_v1", k), v1, 1);
            chk($sformatf("indep%0d_q0", k), q0, 8'h77);
            chk($sformatf("indep%0d_v0", k), v0, 1);
        end

        // Full throughput on output 0: drain and reload every edge.
        r1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            d = 8'(k); dv = 1'b1; sel = 1'b0; r0 = 1'b1;
            #1;
            chk($sformatf("thru%0d_dr", k), dr, 1);
            @(posedge clk); #1;
            chk($sformatf("thru%0d_v0", k), v0, 1);
            chk($sformatf("thru%0d_q0", k), q0, k);
        end
        dv = 1'b0; r0 = 1'b1; r1 = 1'b1;
        @(posedge clk); #1;
        chk("drain_v0", v0, 0);
        chk("drain_v1", v1, 0);
        chk("drain_q0_hold", q0, 8'h0F);
        chk("drain_q1_hold", q1, 8'h04);

        // Asynchronous reset between edges with output 0 full.
        d = 8'hA5; dv = 1'b1; sel = 1'b0; r0 = 1'b0; r1 = 1'b0;
        @(posedge clk); #1;
        dv = 1'b0;
        chk("prerst_v0", v0, 1);
        chk("prerst_q0", q0, 8'hA5);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_v0", v0, 0);
        chk("arst_v1", v1, 0);
        chk("arst_q0", q0, 0);
        chk("arst_q1", q1, 0);
        chk("arst_dr", dr, 1);
        @(posedge clk); #4;
        rst = 1'b0;

        // Randomized traffic against the queue model.
        last0 = 8'h00; last1 = 8'h00;
        mq0.delete(); mq1.delete();
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            chk("rnd_v0", v0, (mq0.size() != 0));
            chk("rnd_v1", v1, (mq1.size() != 0));
            chk("rnd_q0", q0, last0);
            chk("rnd_q1", q1, last1);
            d   = 8'($urandom);
            dv  = 1'($urandom_range(0, 1));
            sel = 1'($urandom_range(0, 1));
            r0  = ($urandom_range(0, 3) != 0);
            r1  = ($urandom_range(0, 2) == 0);
            #1;
            tk0 = (mq0.size() != 0) && r0;
            tk1 = (mq1.size() != 0) && r1;
            mdr = sel ? ((mq1.size() == 0) || r1) : ((mq0.size() == 0) || r0);
            acc = dv && mdr;
            chk("rnd_dr", dr, mdr);
            if (tk0) void'(mq0.pop_front());
            if (tk1) void'(mq1.pop_front());
            if (acc) begin
                if (sel) begin mq1.push_back(d); last1 = d; end
                else     begin mq0.push_back(d); last0 = d; end
            end
        end
        @(posedge clk); #1;
        chk("rnd_end_v0", v0, (mq0.size() != 0));
        chk("rnd_end_v1", v1, (mq1.size() != 0));
        dv = 1'b0;

`ifdef BYTE_DEMUX_CNT_EN
        #2;
        rst = 1'b1;
        #1;
        chk("cnt_rst0", cnt0, 0);
        chk("cnt_rst1", cnt1, 0);
        @(posedge clk); #4;
        rst = 1'b0;
        @(posedge clk); #1;
        dv = 1'b1; sel = 1'b1; r0 = 1'b0; r1 = 1'b1;
        for (int k = 0; k < 257; k++) begin
            d = 8'(k);
            @(posedge clk); #1;
        end
        dv = 1'b0;
        @(posedge clk); #1;
        chk("cnt1_wrap", cnt1, 8'd1);
        chk("cnt0_idle", cnt0, 8'd0);
        chk("cnt_v1", v1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
